// File: rtl/simultaneous_to_sequential_reg.sv
// Parallel-to-serial converter: captures a word of SHIFT_LEN lanes on a
// valid/ready handshake and replays it one lane per accepted output beat.
// A new word can be accepted on the last beat, so back-to-back words
// stream without bubbles.
module simultaneous_to_sequential_reg #(
  parameter int BIT_WIDTH = 2,
  parameter int SHIFT_LEN = 4,
  parameter int DIRECTION = 1
) (
  input  logic                           clk,
  input  logic                           in_ctr_rst_n,
  input  logic                           in_ctr_Srst,
  input  logic                           in_load_valid,
  output logic                           out_load_ready,
  input  logic [BIT_WIDTH*SHIFT_LEN-1:0] in,
  output logic [BIT_WIDTH-1:0]           out,
  output logic                           out_valid,
  input  logic                           in_out_ready,
  output logic                           out_last
);

  localparam int CW = $clog2(SHIFT_LEN) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(SHIFT_LEN - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]                     state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [BIT_WIDTH*SHIFT_LEN-1:0] buf_q, buf_d;

  logic [CW-1:0]        lane_sel;
  logic [BIT_WIDTH-1:0] lane_data;
  logic                 load_hs;
  logic                 beat_hs;

  // Handshake and status decode; load is also accepted on the closing beat.
  assign out_valid      = (state_q == ST_SHIFT);
  assign out_last       = out_valid && (cnt_q == LAST_IDX);
  assign out_load_ready = (state_q == ST_IDLE) || (out_last && in_out_ready);
  assign load_hs        = in_load_valid && out_load_ready;
  assign beat_hs        = out_valid && in_out_ready;

  // Lane order: counter walks upward; reversed order mirrors the index.
  assign lane_sel = (DIRECTION > 0) ? cnt_q : (LAST_IDX - cnt_q);

  // Lane multiplexer written as a compare loop so the index width never
  // has to match the lane count.
  always_comb begin
    lane_data = '0;
    for (int k = 0; k < SHIFT_LEN; k++) begin
      if (lane_sel == CW'(k)) begin
        lane_data = buf_q[k*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // The buffer is kept after the word ends, so gate it off while idle.
  assign out = out_valid ? lane_data : '0;

  // Next-state logic: a load wins over the beat (covers the zero-bubble
  // reload on the last beat); otherwise advance or close the word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    if (load_hs) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
      buf_d   = in;
    end else if (beat_hs) begin
      if (out_last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers: async reset, then synchronous clear with top priority.
  always_ff @(posedge clk or negedge in_ctr_rst_n) begin
    if (!in_ctr_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else if (in_ctr_Srst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_simultaneous_to_sequential_reg.sv
// Bench for simultaneous_to_sequential_reg: two 4x3 instances sharing
// stimulus (lane order up and down) plus a single-lane instance.
// Reference model: a queue of lanes still to be emitted per instance.
module tb_simultaneous_to_sequential_reg;

  logic        clk;
  logic        rst_n;
  logic        srst;
  logic        lv;
  logic [11:0] din;
  logic        ordy;
  logic        lr1, ov1, ol1;
  logic [3:0]  o1;
  logic        lr0, ov0, ol0;
  logic [3:0]  o0;
  logic        s_lv, s_ordy, s_lr, s_ov, s_ol;
  logic [3:0]  s_din, s_o;

  int checks   = 0;
  int failures = 0;

  logic [3:0] q1[$];
  logic [3:0] q0[$];
  logic [3:0] qs[$];

  simultaneous_to_sequential_reg #(.BIT_WIDTH(4), .SHIFT_LEN(3), .DIRECTION(1)) u_up (
    .clk(clk), .in_ctr_rst_n(rst_n), .in_ctr_Srst(srst), .in_load_valid(lv),
    .out_load_ready(lr1), .in(din), .out(o1), .out_valid(ov1),
    .in_out_ready(ordy), .out_last(ol1));

  simultaneous_to_sequential_reg #(.BIT_WIDTH(4), .SHIFT_LEN(3), .DIRECTION(0)) u_dn (
    .clk(clk), .in_ctr_rst_n(rst_n), .in_ctr_Srst(srst), .in_load_valid(lv),
    .out_load_ready(lr0), .in(din), .out(o0), .out_valid(ov0),
    .in_out_ready(ordy), .out_last(ol0));

  simultaneous_to_sequential_reg #(.BIT_WIDTH(4), .SHIFT_LEN(1), .DIRECTION(1)) u_one (
    .clk(clk), .in_ctr_rst_n(rst_n), .in_ctr_Srst(srst), .in_load_valid(s_lv),
    .out_load_ready(s_lr), .in(s_din), .out(s_o), .out_valid(s_ov),
    .in_out_ready(s_ordy), .out_last(s_ol));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and update the lane queues from the inputs seen at the edge.
  task automatic step();
    bit rdy_ok, ld, bt;
    @(posedge clk);
    if (srst) begin
      q1.delete(); q0.delete(); qs.delete();
    end else begin
      rdy_ok = (q1.size() == 0) || (q1.size() == 1 && ordy);
      ld = lv && rdy_ok;
      bt = (q1.size() != 0) && ordy;
      if (bt) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
      end
      if (ld) begin
        for (int k = 0; k < 3; k++) begin
          q1.push_back(din[4*k +: 4]);
          q0.push_back(din[4*(2-k) +: 4]);
        end
      end
      rdy_ok = (qs.size() == 0) || (qs.size() == 1 && s_ordy);
      ld = s_lv && rdy_ok;
      bt = (qs.size() != 0) && s_ordy;
      if (bt) void'(qs.pop_front());
      if (ld) qs.push_back(s_din);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({ov1, ol1, o1, lr1} !== 7'b0000001)
      begin failures++; $display("FAIL reset_up got=%b exp=0000001", {ov1, ol1, o1, lr1}); end
    checks++;
    if ({ov0, ol0, o0, lr0} !== 7'b0000001)
      begin failures++; $display("FAIL reset_dn got=%b exp=0000001", {ov0, ol0, o0, lr0}); end
    checks++;
    if ({s_ov, s_ol, s_o, s_lr} !== 7'b0000001)
      begin failures++; $display("FAIL reset_one got=%b exp=0000001", {s_ov, s_ol, s_o, s_lr}); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    #1;
    checks++;
    if ({ov1, ol1, o1, lr1} !== 7'b0000001)
      begin failures++; $display("FAIL reset_release got=%b exp=0000001", {ov1, ol1, o1, lr1}); end
  endtask

  task automatic test_direction();
    logic [3:0] e1[3];
    logic [3:0] e0[3];
    e1 = '{4'h1, 4'h2, 4'h3};
    e0 = '{4'h3, 4'h2, 4'h1};
    lv = 1'b1; din = 12'h321; ordy = 1'b1;
    step();
    lv = 1'b0; din = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({ov1, ol1, o1} !== {1'b1, (i == 2), e1[i]})
        begin failures++; $display("FAIL dir_up beat%0d got=%b exp=%b", i, {ov1, ol1, o1}, {1'b1, (i == 2), e1[i]}); end
      checks++;
      if ({ov0, ol0, o0} !== {1'b1, (i == 2), e0[i]})
        begin failures++; $display("FAIL dir_dn beat%0d got=%b exp=%b", i, {ov0, ol0, o0}, {1'b1, (i == 2), e0[i]}); end
      step();
    end
    #1;
    checks++;
    if ({ov1, ol1, o1, lr1, ov0, o0} !== {7'b0000001, 5'b00000})
      begin failures++; $display("FAIL dir_idle got=%b exp=000000100000", {ov1, ol1, o1, lr1, ov0, o0}); end
  endtask

  task automatic test_backpressure();
    lv = 1'b1; din = 12'h321; ordy = 1'b1;
    step();
    lv = 1'b0;
    #1;
    checks++;
    if (o1 !== 4'h1) begin failures++; $display("FAIL bp_lane0 got=%h exp=1", o1); end
    step();
    ordy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({ov1, ol1, o1, lr1} !== {1'b1, 1'b0, 4'h2, 1'b0})
        begin failures++; $display("FAIL bp_hold%0d got=%b exp=1000100", i, {ov1, ol1, o1, lr1}); end
      step();
    end
    ordy = 1'b1;
    #1;
    checks++;
    if ({ov1, o1} !== {1'b1, 4'h2}) begin failures++; $display("FAIL bp_release got=%b exp=10010", {ov1, o1}); end
    step();
    #1;
    checks++;
    if ({ov1, ol1, o1} !== {1'b1, 1'b1, 4'h3}) begin failures++; $display("FAIL bp_last got=%b exp=110011", {ov1, ol1, o1}); end
    step();
    #1;
    checks++;
    if ({ov1, o1} !== 5'b00000) begin failures++; $display("FAIL bp_idle got=%b exp=00000", {ov1, o1}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e1[6];
    logic [3:0] e0[6];
    e1 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    e0 = '{4'h3, 4'h2, 4'h1, 4'h6, 4'h5, 4'h4};
    lv = 1'b1; din = 12'h321; ordy = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       begin lv = 1'b1; din = 12'h999; end
        2:       begin lv = 1'b1; din = 12'h654; end
        default: begin lv = 1'b0; din = '0; end
      endcase
      #1;
      checks++;
      if ({ov1, ol1, o1} !== {1'b1, (i % 3 == 2), e1[i]})
        begin failures++; $display("FAIL b2b_up beat%0d got=%b exp=%b", i, {ov1, ol1, o1}, {1'b1, (i % 3 == 2), e1[i]}); end
      checks++;
      if ({ov0, o0} !== {1'b1, e0[i]})
        begin failures++; $display("FAIL b2b_dn beat%0d got=%b exp=%b", i, {ov0, o0}, {1'b1, e0[i]}); end
      checks++;
      if (lr1 !== (i % 3 == 2))
        begin failures++; $display("FAIL b2b_ready beat%0d got=%b exp=%b", i, lr1, (i % 3 == 2)); end
      step();
    end
    #1;
    checks++;
    if ({ov1, o1} !== 5'b00000) begin failures++; $display("FAIL b2b_idle got=%b exp=00000", {ov1, o1}); end
  endtask

  task automatic test_single_lane();
    logic [3:0] v[3];
    v = '{4'hA, 4'hB, 4'hC};
    s_ordy = 1'b1; s_lv = 1'b1; s_din = v[0];
    step();
    for (int i = 0; i < 3; i++) begin
      s_lv  = (i < 2);
      s_din = (i < 2) ? v[i+1] : 4'h0;
      #1;
      checks++;
      if ({s_ov, s_ol, s_o, s_lr} !== {1'b1, 1'b1, v[i], 1'b1})
        begin failures++; $display("FAIL one_beat%0d got=%b exp=%b", i, {s_ov, s_ol, s_o, s_lr}, {1'b1, 1'b1, v[i], 1'b1}); end
      step();
    end
    #1;
    checks++;
    if ({s_ov, s_ol, s_o, s_lr} !== 7'b0000001)
      begin failures++; $display("FAIL one_idle got=%b exp=0000001", {s_ov, s_ol, s_o, s_lr}); end
  endtask

  task automatic test_async_reset();
    lv = 1'b1; din = 12'h321; ordy = 1'b1;
    step();
    lv = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ov1, ol1, o1, lr1, ov0, o0} !== {7'b0000001, 5'b00000})
      begin failures++; $display("FAIL arst_drop got=%b exp=000000100000", {ov1, ol1, o1, lr1, ov0, o0}); end
    q1.delete(); q0.delete(); qs.delete();
    #1 rst_n = 1'b1;
    step();
    #1;
    checks++;
    if ({ov1, o1} !== 5'b00000) begin failures++; $display("FAIL arst_stay_idle got=%b exp=00000", {ov1, o1}); end
    lv = 1'b1; din = 12'h321;
    step();
    lv = 1'b0;
    #1;
    checks++;
    if ({ov1, o1, o0} !== {1'b1, 4'h1, 4'h3})
      begin failures++; $display("FAIL arst_restart got=%b exp=100010011", {ov1, o1, o0}); end
    step(); step(); step();
  endtask

  task automatic test_sync_clear();
    lv = 1'b1; din = 12'h321; ordy = 1'b1;
    step();
    lv = 1'b0;
    step();
    srst = 1'b1; lv = 1'b1; din = 12'h654;
    #1;
    checks++;
    if ({ov1, o1} !== {1'b1, 4'h2}) begin failures++; $display("FAIL srst_before_edge got=%b exp=10010", {ov1, o1}); end
    step();
    srst = 1'b0; lv = 1'b0; din = '0;
    #1;
    checks++;
    if ({ov1, ol1, o1, lr1, ov0, o0} !== {7'b0000001, 5'b00000})
      begin failures++; $display("FAIL srst_clear got=%b exp=000000100000", {ov1, ol1, o1, lr1, ov0, o0}); end
    step();
    #1;
    checks++;
    if (ov1 !== 1'b0) begin failures++; $display("FAIL srst_no_partial got=%b exp=0", ov1); end
    lv = 1'b1; din = 12'h321;
    step();
    lv = 1'b0;
    #1;
    checks++;
    if ({ov1, o1, o0} !== {1'b1, 4'h1, 4'h3})
      begin failures++; $display("FAIL srst_restart got=%b exp=100010011", {ov1, o1, o0}); end
    step(); step(); step();
  endtask

  task automatic test_random();
    logic [6:0] e;
    for (int c = 0; c < 400; c++) begin
      lv     = 1'($urandom_range(0, 1));
      din    = 12'($urandom);
      ordy   = ($urandom_range(0, 3) != 0);
      srst   = ($urandom_range(0, 49) == 0);
      s_lv   = 1'($urandom_range(0, 1));
      s_din  = 4'($urandom);
      s_ordy = ($urandom_range(0, 3) != 0);
      #1;
      e = {q1.size() != 0, q1.size() == 1, (q1.size() != 0) ? q1[0] : 4'h0,
           (q1.size() == 0) || (q1.size() == 1 && ordy)};
      checks++;
      if ({ov1, ol1, o1, lr1} !== e)
        begin failures++; $display("FAIL rand_up cyc%0d got=%b exp=%b", c, {ov1, ol1, o1, lr1}, e); end
      e = {q0.size() != 0, q0.size() == 1, (q0.size() != 0) ? q0[0] : 4'h0,
           (q0.size() == 0) || (q0.size() == 1 && ordy)};
      checks++;
      if ({ov0, ol0, o0, lr0} !== e)
        begin failures++; $display("FAIL rand_dn cyc%0d got=%b exp=%b", c, {ov0, ol0, o0, lr0}, e); end
      e = {qs.size() != 0, qs.size() == 1, (qs.size() != 0) ? qs[0] : 4'h0,
           (qs.size() == 0) || (qs.size() == 1 && s_ordy)};
      checks++;
      if ({s_ov, s_ol, s_o, s_lr} !== e)
        begin failures++; $display("FAIL rand_one cyc%0d got=%b exp=%b", c, {s_ov, s_ol, s_o, s_lr}, e); end
      step();
    end
    srst = 1'b0; lv = 1'b0; s_lv = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; srst = 1'b0; lv = 1'b0; din = '0; ordy = 1'b0;
    s_lv = 1'b0; s_din = '0; s_ordy = 1'b0;
    test_reset();
    test_direction();
    test_backpressure();
    test_back_to_back();
    test_single_lane();
    test_async_reset();
    test_sync_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
